hex_decimal_display: RTL and testbench

- Consumer end of the CPU's 32-bit GPIO output (`out`, written by the hex-display CSR write). It watches that bus and converts each new value to decimal with an iterative double-dabble (shift-add-3).
- It drives eight active-low seven-segment digits showing the value's low 8 decimal digits.
- It sits at board top level, between the CPU's `out` and the HEX0..HEX7 pins.

---
 rtl/hex_decimal_display.sv | 152 +++++++++++++++
 tb/tb_hex_decimal_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_decimal_display.sv
// Watches the CPU GPIO word and shows its low eight decimal digits on HEX0..HEX7.
// The decimal digits come from an iterative double-dabble that handles one input bit per cycle.
module hex_decimal_display #(
    parameter int WIDTH      = 32,
    parameter int BCD_DIGITS = 10,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic             clck,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5,
    output logic [6:0]       hex6,
    output logic [6:0]       hex7,
    output logic             busy,
    output logic             overflow
);

    localparam int          CW       = $clog2(WIDTH);
    localparam int          BW       = 4 * BCD_DIGITS;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;
    localparam logic [6:0]  SEG_BLNK = 7'b1111111;
    localparam logic [6:0]  LZ_RESET = BLANK_LZ ? SEG_BLNK : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        LOAD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  last_val;
    logic [WIDTH-1:0]  bin;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [CW-1:0]     count;
    logic [6:0]        seg_q    [8];
    logic [6:0]        seg_next [8];
    logic              upper_zero;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (value != last_val) state_next = CONVERT;
            CONVERT: if (count == LAST) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Digit k blanks only when it and every digit above it (up to digit 7) is zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
            seg_next[k] = SEG_BLNK;
        end
        for (int k = 7; k >= 1; k--) begin
            upper_zero = upper_zero && (bcd[4*k +: 4] == 4'd0);
            seg_next[k] = (BLANK_LZ && upper_zero) ? SEG_BLNK : seg_of(bcd[4*k +: 4]);
        end
        seg_next[0] = seg_of(bcd[3:0]);
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            last_val <= '0;
            bin      <= '0;
            bcd      <= '0;
            count    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            seg_q[0] <= SEG_ZERO;
            for (int k = 1; k < 8; k++) begin
                seg_q[k] <= LZ_RESET;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (value != last_val) begin
                        last_val <= value;
                        bin      <= value;
                        bcd      <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    count      <= count + CW'(1);
                end
                LOAD: begin
                    for (int k = 0; k < 8; k++) begin
                        seg_q[k] <= seg_next[k];
                    end
                    overflow <= (bcd[BW-1:32] != '0);
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hex0 = seg_q[0];
    assign hex1 = seg_q[1];
    assign hex2 = seg_q[2];
    assign hex3 = seg_q[3];
    assign hex4 = seg_q[4];
    assign hex5 = seg_q[5];
    assign hex6 = seg_q[6];
    assign hex7 = seg_q[7];

endmodule

// File: tb/tb_hex_decimal_display.sv
// Scoreboard bench for hex_decimal_display: expected displays are queued at stimulus time
// and checked by a monitor each time busy falls after a completed conversion.
module tb_hex_decimal_display;

    localparam int LAT = 33;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        string       name;
        logic [55:0] segs;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy;
    logic        overflow;

    int   checks;
    int   errors;
    int   cyc;
    exp_t exp_q[$];

    hex_decimal_display #(
        .WIDTH(32),
        .BCD_DIGITS(10),
        .BLANK_LZ(1'b1)
    ) dut (
        .clck(clk),
        .rst_n(rst_n),
        .value(value),
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3),
        .hex4(hex4),
        .hex5(hex5),
        .hex6(hex6),
        .hex7(hex7),
        .busy(busy),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [55:0] segsNow();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    // Caller sits at a negedge, so the next rising edge is the capture edge.
    task automatic applyStimulus(input logic [31:0] v, output int due);
        value = v;
        due   = cyc + 1 + LAT;
    endtask

    task automatic pushExp(input string name, input logic [55:0] segs, input logic ovf, input int due);
        exp_t e;
        e.name = name;
        e.segs = segs;
        e.ovf  = ovf;
        e.due  = due;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [55:0] segs, input logic ovf, input logic bsy);
        checks += 3;
        if (segsNow() !== segs) begin
            errors++;
            $display("[TB] FAIL %s segs got %h want %h", name, segsNow(), segs);
        end
        if (overflow !== ovf) begin
            errors++;
            $display("[TB] FAIL %s overflow got %b want %b", name, overflow, ovf);
        end
        if (busy !== bsy) begin
            errors++;
            $display("[TB] FAIL %s busy got %b want %b", name, busy, bsy);
        end
    endtask

    // Monitor: a busy 1->0 transition outside reset marks a freshly loaded display.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_load at cycle %0d segs %h", cyc, segsNow());
                    end else begin
                        e = exp_q.pop_front();
                        checks += 3;
                        if (segsNow() !== e.segs) begin
                            errors++;
                            $display("[TB] FAIL %s segs got %h want %h", e.name, segsNow(), e.segs);
                        end
                        if (overflow !== e.ovf) begin
                            errors++;
                            $display("[TB] FAIL %s overflow got %b want %b", e.name, overflow, e.ovf);
                        end
                        if (cyc != e.due) begin
                            errors++;
                            $display("[TB] FAIL %s load_cycle got %0d want %0d", e.name, cyc, e.due);
                        end
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        int due;
        int due5;
        int busy_hits;
        logic [55:0] reset_segs;

        checks     = 0;
        errors     = 0;
        reset_segs = {SB, SB, SB, SB, SB, SB, SB, S0};
        rst_n      = 1'b0;
        value      = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset", reset_segs, 1'b0, 1'b0);

        rst_n     = 1'b1;
        busy_hits = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) busy_hits++;
        end
        checks++;
        if (busy_hits != 0) begin
            errors++;
            $display("[TB] FAIL idle_zero busy_cycles got %0d want 0", busy_hits);
        end
        checkOutput("idle_zero", reset_segs, 1'b0, 1'b0);

        applyStimulus(32'd1234, due);
        pushExp("v1234", {SB, SB, SB, SB, S1, S2, S3, S4}, 1'b0, due);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_after_capture got %b want 1", busy);
        end
        repeat (40) @(negedge clk);

        applyStimulus(32'd99999999, due);
        pushExp("v99999999", {8{S9}}, 1'b0, due);
        repeat (40) @(negedge clk);

        applyStimulus(32'd100000000, due);
        pushExp("v100000000", {SB, SB, SB, SB, SB, SB, SB, S0}, 1'b1, due);
        repeat (40) @(negedge clk);

        applyStimulus(32'hFFFF_FFFF, due);
        pushExp("vmax", {S9, S4, S9, S6, S7, S2, S9, S5}, 1'b1, due);
        repeat (40) @(negedge clk);

        applyStimulus(32'd5, due5);
        pushExp("v5", {SB, SB, SB, SB, SB, SB, SB, S5}, 1'b0, due5);
        repeat (10) @(negedge clk);
        value = 32'd7;
        pushExp("v7", {SB, SB, SB, SB, SB, SB, SB, S7}, 1'b0, due5 + 1 + LAT);
        repeat (due5 - cyc) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_busy_low got %b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gap_busy_restart got %b want 1", busy);
        end
        repeat (40) @(negedge clk);

        applyStimulus(32'd42, due);
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #2 checkOutput("async_reset", reset_segs, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pushExp("v42", {SB, SB, SB, SB, SB, SB, S4, S2}, 1'b0, cyc + 1 + LAT);
        repeat (45) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_loads got %0d want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
